// File: rtl/dcache_port_arbiter_pkg.sv
// Shared types and defaults for the data-cache port arbiter.
// Holds the FSM state encoding, default bus widths and the grant decision helper.
// Imported by the arbiter and by anything that inspects its state.
package dcache_port_arbiter_pkg;

    localparam int DPORT_ADDR_W = 32;
    localparam int DPORT_DATA_W = 32;
    localparam int DPORT_MASK_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_WR_WAIT = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_RESP    = 3'd4
    } dport_state_t;

    // Stores normally win; a waiting load only wins alone or once it has been starved.
    function automatic logic load_wins(input logic load_pend,
                                       input logic store_pend,
                                       input logic starved);
        return load_pend && (!store_pend || starved);
    endfunction

endpackage

// File: rtl/dcache_port_arbiter.sv
// Purpose: shares one dcache port between speculative loads and commit-time stores, one op in flight.
// Latency: grant cycle N, mem_req from N+1; mem_done at K gives the done pulse at K+1, IDLE at K+2.
// Backpressure: requesters hold their request until their done pulse; the cache holds off via mem_done.
module dcache_port_arbiter
    import dcache_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DPORT_ADDR_W,
    parameter int DATA_W       = DPORT_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    lsm_read,
    input  logic [ADDR_W-1:0]       lsm_read_addr,
    output logic                    lsm_read_done,
    output logic [DATA_W-1:0]       lsm_read_data,
    input  logic                    rob_write,
    input  logic [DPORT_MASK_W-1:0] rob_mask,
    input  logic [ADDR_W-1:0]       rob_addr,
    input  logic [DATA_W-1:0]       rob_data,
    output logic                    rob_write_valid,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [DPORT_MASK_W-1:0] mem_mask,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic                    mem_done,
    input  logic [DATA_W-1:0]       mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    dport_state_t     state;
    logic [CNT_W-1:0] starve_cnt;
    logic             load_pend;
    logic             starved;
    logic             grant_load;
    logic             grant_store;

    // Grant decision for the current IDLE cycle; a flush masks the load for that cycle only.
    always_comb begin
        load_pend   = lsm_read && !flush;
        starved     = (starve_cnt == CNT_MAX);
        grant_load  = load_wins(load_pend, rob_write, starved);
        grant_store = rob_write && !grant_load;
    end

    // Port FSM with registered cache-side and requester-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            starve_cnt      <= '0;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_mask        <= '0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            lsm_read_done   <= 1'b0;
            lsm_read_data   <= '0;
            rob_write_valid <= 1'b0;
        end else begin
            lsm_read_done   <= 1'b0;
            rob_write_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_load) begin
                        state    <= ST_RD_WAIT;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_mask <= '0;
                        mem_addr <= lsm_read_addr;
                    end else if (grant_store) begin
                        state     <= ST_WR_WAIT;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_mask  <= rob_mask;
                        mem_addr  <= rob_addr;
                        mem_wdata <= rob_data;
                    end
                    // Counter only tracks stores that overtook a visible load.
                    if (!lsm_read || grant_load) begin
                        starve_cnt <= '0;
                    end else if (grant_store && !starved) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                ST_RD_WAIT: begin
                    if (flush) begin
                        // A completion coinciding with the flush ends the access at once.
                        if (mem_done) begin
                            state   <= ST_IDLE;
                            mem_req <= 1'b0;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end else if (mem_done) begin
                        state         <= ST_RESP;
                        mem_req       <= 1'b0;
                        lsm_read_done <= 1'b1;
                        lsm_read_data <= mem_rdata;
                    end
                end
                ST_WR_WAIT: begin
                    if (mem_done) begin
                        state           <= ST_RESP;
                        mem_req         <= 1'b0;
                        rob_write_valid <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Cancelled load: finish the cache handshake, drop the data silently.
                    if (mem_done) begin
                        state   <= ST_IDLE;
                        mem_req <= 1'b0;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
module tb_dcache_port_arbiter;
    import dcache_port_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        lsm_read;
    logic [31:0] lsm_read_addr;
    logic        lsm_read_done;
    logic [31:0] lsm_read_data;
    logic        rob_write;
    logic [3:0]  rob_mask;
    logic [31:0] rob_addr;
    logic [31:0] rob_data;
    logic        rob_write_valid;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_mask;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;
    int n_rd  = 0;
    int n_wr  = 0;

    dcache_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .lsm_read(lsm_read), .lsm_read_addr(lsm_read_addr),
        .lsm_read_done(lsm_read_done), .lsm_read_data(lsm_read_data),
        .rob_write(rob_write), .rob_mask(rob_mask), .rob_addr(rob_addr), .rob_data(rob_data),
        .rob_write_valid(rob_write_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_mask(mem_mask), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Count done pulses so duplicates show up as wrong totals.
    always @(posedge clk) begin
        if (lsm_read_done)   n_rd++;
        if (rob_write_valid) n_wr++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Cache model: wait for mem_req, check the request, complete after dly cycles.
    task automatic serve(input string tag, input int dly, input logic we,
                         input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] wd, input logic [31:0] rd);
        int n = 0;
        while (!mem_req && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_req"}, 64'(mem_req), 64'd1);
        chk({tag, "_we"}, 64'(mem_we), 64'(we));
        chk({tag, "_addr"}, 64'(mem_addr), 64'(addr));
        chk({tag, "_mask"}, 64'(mem_mask), 64'(mask));
        if (we) chk({tag, "_wdata"}, 64'(mem_wdata), 64'(wd));
        repeat (dly) step();
        chk({tag, "_hold"}, 64'(mem_req), 64'd1);
        mem_rdata = rd;
        mem_done  = 1'b1;
        step();
        mem_done  = 1'b0;
        chk({tag, "_reqdrop"}, 64'(mem_req), 64'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; lsm_read = 1'b0; lsm_read_addr = '0;
        rob_write = 1'b0; rob_mask = '0; rob_addr = '0; rob_data = '0;
        mem_done = 1'b0; mem_rdata = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_rdone", 64'(lsm_read_done), 64'd0);
        chk("rst_wvalid", 64'(rob_write_valid), 64'd0);
        chk("rst_rdata", 64'(lsm_read_data), 64'd0);
        chk("rst_state", 64'(dut.state), 64'(ST_IDLE));
        chk("rst_cnt", 64'(dut.starve_cnt), 64'd0);

        // Stray mem_done in IDLE is ignored.
        mem_done = 1'b1; step(); mem_done = 1'b0;
        chk("stray_req", 64'(mem_req), 64'd0);
        chk("stray_rdone", 64'(lsm_read_done), 64'd0);
        chk("stray_wvalid", 64'(rob_write_valid), 64'd0);

        // T1: load only.
        lsm_read = 1'b1; lsm_read_addr = 32'h100;
        step();
        serve("t1", 3, 1'b0, 32'h100, 4'h0, 32'h0, 32'hDEADBEEF);
        chk("t1_done", 64'(lsm_read_done), 64'd1);
        chk("t1_data", 64'(lsm_read_data), 64'hDEADBEEF);
        lsm_read = 1'b0;
        step();
        chk("t1_pulse1", 64'(lsm_read_done), 64'd0);
        chk("t1_dhold", 64'(lsm_read_data), 64'hDEADBEEF);
        step();

        // T2: simultaneous load and store, store first.
        lsm_read = 1'b1; lsm_read_addr = 32'h300;
        rob_write = 1'b1; rob_mask = 4'b0011; rob_addr = 32'h200; rob_data = 32'h1234;
        step();
        serve("t2s", 1, 1'b1, 32'h200, 4'b0011, 32'h1234, 32'h0);
        chk("t2_wvalid", 64'(rob_write_valid), 64'd1);
        chk("t2_no_rdone", 64'(lsm_read_done), 64'd0);
        chk("t2_cnt", 64'(dut.starve_cnt), 64'd1);
        rob_write = 1'b0;
        step();
        chk("t2_wpulse1", 64'(rob_write_valid), 64'd0);
        chk("t2_noregrant", 64'(mem_req), 64'd0);
        serve("t2l", 0, 1'b0, 32'h300, 4'h0, 32'h0, 32'hCAFE0001);
        chk("t2_rdone", 64'(lsm_read_done), 64'd1);
        chk("t2_rdata", 64'(lsm_read_data), 64'hCAFE0001);
        lsm_read = 1'b0;
        step(); step(); step();
        chk("t2_nreq", 64'(mem_req), 64'd0);
        chk("t2_nrd", 64'(n_rd), 64'd2);
        chk("t2_nwr", 64'(n_wr), 64'd1);

        // T3: starvation guard after four overtaking stores.
        lsm_read = 1'b1; lsm_read_addr = 32'h400; rob_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rob_addr = 32'h500 + 32'(i * 4); rob_data = 32'(i + 1); rob_mask = 4'hF;
            serve($sformatf("t3s%0d", i), 0, 1'b1, 32'h500 + 32'(i * 4), 4'hF, 32'(i + 1), 32'h0);
            chk($sformatf("t3_wv%0d", i), 64'(rob_write_valid), 64'd1);
            chk($sformatf("t3_cnt%0d", i), 64'(dut.starve_cnt), 64'(i + 1));
        end
        serve("t3l", 0, 1'b0, 32'h400, 4'h0, 32'h0, 32'h11112222);
        chk("t3_rdone", 64'(lsm_read_done), 64'd1);
        chk("t3_rdata", 64'(lsm_read_data), 64'h11112222);
        chk("t3_cnt_clr", 64'(dut.starve_cnt), 64'd0);
        lsm_read = 1'b0; rob_write = 1'b0;
        step(); step();

        // T4: flush one cycle into RD_WAIT, queued store follows DRAIN.
        lsm_read = 1'b1; lsm_read_addr = 32'h600;
        step();
        chk("t4_req", 64'(mem_req), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0; lsm_read = 1'b0;
        rob_write = 1'b1; rob_addr = 32'h700; rob_data = 32'h77; rob_mask = 4'b1100;
        chk("t4_drain", 64'(dut.state), 64'(ST_DRAIN));
        chk("t4_hold0", 64'(mem_req), 64'd1);
        step(); step();
        chk("t4_hold2", 64'(mem_req), 64'd1);
        chk("t4_we", 64'(mem_we), 64'd0);
        mem_rdata = 32'h00000BAD; mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        chk("t4_reqdrop", 64'(mem_req), 64'd0);
        chk("t4_no_rdone", 64'(lsm_read_done), 64'd0);
        step();
        chk("t4_sgrant", 64'(mem_req), 64'd1);
        chk("t4_swe", 64'(mem_we), 64'd1);
        serve("t4s", 0, 1'b1, 32'h700, 4'b1100, 32'h77, 32'h0);
        chk("t4_wvalid", 64'(rob_write_valid), 64'd1);
        chk("t4_rdata_held", 64'(lsm_read_data), 64'h11112222);
        rob_write = 1'b0;
        step(); step();

        // T5: flush during WR_WAIT does not cancel the store.
        rob_write = 1'b1; rob_addr = 32'h800; rob_data = 32'h55AA; rob_mask = 4'hF;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t5_state", 64'(dut.state), 64'(ST_WR_WAIT));
        serve("t5s", 1, 1'b1, 32'h800, 4'hF, 32'h55AA, 32'h0);
        chk("t5_wvalid", 64'(rob_write_valid), 64'd1);
        rob_write = 1'b0;
        step(); step();

        // T6: reset during RD_WAIT, then a clean load.
        lsm_read = 1'b1; lsm_read_addr = 32'h900;
        step();
        chk("t6_req", 64'(mem_req), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_req0", 64'(mem_req), 64'd0);
        chk("t6_we0", 64'(mem_we), 64'd0);
        chk("t6_mask0", 64'(mem_mask), 64'd0);
        chk("t6_addr0", 64'(mem_addr), 64'd0);
        chk("t6_wdata0", 64'(mem_wdata), 64'd0);
        chk("t6_rdata0", 64'(lsm_read_data), 64'd0);
        chk("t6_state", 64'(dut.state), 64'(ST_IDLE));
        serve("t6l", 0, 1'b0, 32'h900, 4'h0, 32'h0, 32'h600DF00D);
        chk("t6_rdone", 64'(lsm_read_done), 64'd1);
        chk("t6_rdata", 64'(lsm_read_data), 64'h600DF00D);
        lsm_read = 1'b0;
        step(); step(); step();
        chk("end_nrd", 64'(n_rd), 64'd4);
        chk("end_nwr", 64'(n_wr), 64'd7);
        chk("end_req", 64'(mem_req), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
